// File: rtl/exe_stage.sv
// exe_stage: execute stage (ALU, data-SRAM request, optional divider).
// Define EXE_DIV_EN to build the 32-step restoring divider.

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    // one-hot op select: add sub slt sltu and nor or xor sll srl sra lui
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] sra_res;
    logic [4:0]  shamt;

    assign shamt    = alu_src2[4:0];
    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
    assign sltu_res = {31'b0, alu_src1 < alu_src2};
    assign sra_res  = $unsigned($signed(alu_src1) >>> shamt);

    // AND-OR mux so an all-zero op yields zero
    always_comb begin
        alu_result = '0;
        alu_result = ({32{alu_op[0]}}  & add_res)
                   | ({32{alu_op[1]}}  & sub_res)
                   | ({32{alu_op[2]}}  & slt_res)
                   | ({32{alu_op[3]}}  & sltu_res)
                   | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                   | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                   | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                   | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                   | ({32{alu_op[8]}}  & (alu_src1 << shamt))
                   | ({32{alu_op[9]}}  & (alu_src1 >> shamt))
                   | ({32{alu_op[10]}} & sra_res)
                   | ({32{alu_op[11]}} & alu_src2);
    end
endmodule

module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 156,
    parameter int ES_TO_MS_BUS_WD = 86
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);
    logic                       es_valid;
    logic                       es_ready_go;
    logic                       handover;
    logic [DS_TO_ES_BUS_WD-1:0] payload;

    logic [11:0] alu_op;
    logic [3:0]  load_op;
    logic [2:0]  store_op;
    logic [1:0]  div_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] st_data;
    logic [31:0] pc;

    logic [31:0] alu_result;
    logic [31:0] result;
    logic [1:0]  offset;
    logic [3:0]  wen_raw;

    assign alu_op       = payload[155:144];
    assign load_op      = payload[143:140];
    assign store_op     = payload[139:137];
    assign div_op       = payload[136:135];
    assign res_from_mem = payload[134];
    assign gr_we        = payload[133];
    assign dest         = payload[132:128];
    assign src1         = payload[127:96];
    assign src2         = payload[95:64];
    assign st_data      = payload[63:32];
    assign pc           = payload[31:0];

    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign handover       = es_to_ms_valid && ms_allowin;

    // stage valid bit follows decode whenever the stage can accept
    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
        end
    end

    // payload register captures only accepted instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            payload <= '0;
        end else if (ds_to_es_valid && es_allowin) begin
            payload <= ds_to_es_bus;
        end
    end

    alu u_alu (
        .alu_op     (alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    div_state_t  state;
    div_state_t  state_next;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        q_neg;
    logic        dvs_zero;
    logic        div_start;
    logic        s1_neg;
    logic        s2_neg;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] trial;
    logic [31:0] quotient;

    assign div_start = es_valid && (|div_op);
    assign s1_neg    = div_op[0] && src1[31];
    assign s2_neg    = div_op[0] && src2[31];
    assign abs1      = s1_neg ? (~src1 + 32'd1) : src1;
    assign abs2      = s2_neg ? (~src2 + 32'd1) : src2;
    assign trial     = {rem, quo[31]} - {1'b0, dvs};

    // divider state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // divider next-state: one cycle IDLE, 32 BUSY, hold in DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (div_start) state_next = BUSY;
            BUSY: if (cnt == 6'd31) state_next = DONE;
            DONE: if (handover) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // operand latch and restoring shift-subtract step
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            dvs_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        cnt      <= '0;
                        rem      <= '0;
                        quo      <= abs1;
                        dvs      <= abs2;
                        q_neg    <= s1_neg ^ s2_neg;
                        dvs_zero <= (src2 == 32'd0);
                    end
                end
                BUSY: begin
                    cnt <= cnt + 6'd1;
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= {rem[30:0], quo[31]};
                        quo <= {quo[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = dvs_zero ? 32'hFFFF_FFFF
                       : (q_neg ? (~quo + 32'd1) : quo);
    assign es_ready_go = !(|div_op) || (state == DONE);
    assign result      = (|div_op) ? quotient : alu_result;
`else
    logic unused_div;

    assign unused_div  = ^div_op;
    assign es_ready_go = 1'b1;
    assign result      = alu_result;
`endif

    assign offset         = alu_result[1:0];
    assign data_sram_en   = handover && ((|load_op) || (|store_op));
    assign data_sram_addr = {alu_result[31:2], 2'b00};

    // byte-lane write enables from store width and address offset
    always_comb begin
        wen_raw = 4'b0000;
        if (store_op[0]) begin
            wen_raw = 4'b0001 << offset;
        end else if (store_op[1]) begin
            wen_raw = offset[1] ? 4'b1100 : 4'b0011;
        end else if (store_op[2]) begin
            wen_raw = 4'b1111;
        end
    end

    assign data_sram_wen = data_sram_en ? wen_raw : 4'b0000;

    // replicate narrow store data across every lane
    always_comb begin
        data_sram_wdata = st_data;
        if (store_op[0]) begin
            data_sram_wdata = {4{st_data[7:0]}};
        end else if (store_op[1]) begin
            data_sram_wdata = {2{st_data[15:0]}};
        end
    end

    assign es_to_ms_bus = {11'b0, load_op, res_from_mem, gr_we,
                           dest, result, pc};
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed table plus hand sequences for exe_stage.
// Divider sequences are selected by EXE_DIV_EN.

module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [155:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [85:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] ADD  = 12'h001;
    localparam logic [11:0] SUB  = 12'h002;
    localparam logic [11:0] SLT  = 12'h004;
    localparam logic [11:0] SLTU = 12'h008;
    localparam logic [11:0] AND_ = 12'h010;
    localparam logic [11:0] NOR_ = 12'h020;
    localparam logic [11:0] OR_  = 12'h040;
    localparam logic [11:0] XOR_ = 12'h080;
    localparam logic [11:0] SLL  = 12'h100;
    localparam logic [11:0] SRL  = 12'h200;
    localparam logic [11:0] SRA  = 12'h400;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] alu;
        logic [3:0]  ld;
        logic [2:0]  st;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] sd;
        logic [31:0] res;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [85:0] act,
                       input logic [85:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [155:0] mkbus(
        input logic [11:0] a, input logic [3:0] l, input logic [2:0] s,
        input logic [1:0] d, input logic [4:0] dst, input logic [31:0] s1,
        input logic [31:0] s2, input logic [31:0] sd, input logic [31:0] pc);
        return {a, l, s, d, |l, ~|s, dst, s1, s2, sd, pc};
    endfunction

    function automatic vec_t mkv(
        input logic [11:0] a, input logic [3:0] l, input logic [2:0] s,
        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] sd,
        input logic [31:0] res, input logic en, input logic [3:0] wen,
        input logic [31:0] wdata);
        vec_t v;
        v.alu = a; v.ld = l; v.st = s; v.s1 = s1; v.s2 = s2; v.sd = sd;
        v.res = res; v.en = en; v.wen = wen; v.wdata = wdata;
        return v;
    endfunction

    // present one instruction for a single cycle; returns at the
    // negedge right after the latching edge
    task automatic send(input logic [155:0] b);
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!es_to_ms_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

`ifdef EXE_DIV_EN
    task automatic run_div(input string nm, input logic [1:0] d,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] exp);
        int c;
        send(mkbus(12'h0, 4'h0, 3'h0, d, 5'd3, s1, s2, 32'h0,
                   32'h1c00_0100));
        wait_valid(c);
        chk({nm, "_lat"}, 86'(c), 86'd33);
        chk({nm, "_res"}, 86'(es_to_ms_bus[63:32]), 86'(exp));
        @(negedge clk);
        chk({nm, "_gone"}, 86'(es_to_ms_valid), 86'd0);
    endtask
`endif

    initial begin
        int c;
        logic [155:0] b;
        logic [85:0]  eb;

        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;

        vt.push_back(mkv(ADD,  0, 0, 5, 7, 0, 12, 0, 0, 0));
        vt.push_back(mkv(SUB,  0, 0, 5, 7, 0, 32'hFFFF_FFFE, 0, 0, 0));
        vt.push_back(mkv(SLT,  0, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0));
        vt.push_back(mkv(SLTU, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0));
        vt.push_back(mkv(AND_, 0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0,
                         32'h00F0_000F, 0, 0, 0));
        vt.push_back(mkv(OR_,  0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0,
                         32'hFFF0_0FFF, 0, 0, 0));
        vt.push_back(mkv(XOR_, 0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0,
                         32'hFF00_0FF0, 0, 0, 0));
        vt.push_back(mkv(NOR_, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0));
        vt.push_back(mkv(SLL,  0, 0, 1, 31, 0, 32'h8000_0000, 0, 0, 0));
        vt.push_back(mkv(SRL,  0, 0, 32'h8000_0000, 4, 0,
                         32'h0800_0000, 0, 0, 0));
        vt.push_back(mkv(SRA,  0, 0, 32'h8000_0000, 4, 0,
                         32'hF800_0000, 0, 0, 0));
        vt.push_back(mkv(ADD, 0, 3'b001, 32'h1000, 3, 32'hAB, 32'h1003,
                         1, 4'b1000, 32'hABAB_ABAB));
        vt.push_back(mkv(ADD, 0, 3'b001, 32'h1000, 0, 32'h11CD, 32'h1000,
                         1, 4'b0001, 32'hCDCD_CDCD));
        vt.push_back(mkv(ADD, 0, 3'b001, 32'h1000, 2, 32'h5A, 32'h1002,
                         1, 4'b0100, 32'h5A5A_5A5A));
        vt.push_back(mkv(ADD, 0, 3'b010, 32'h2000, 2, 32'h9999_1234,
                         32'h2002, 1, 4'b1100, 32'h1234_1234));
        vt.push_back(mkv(ADD, 0, 3'b010, 32'h2000, 1, 32'h0000_BEEF,
                         32'h2001, 1, 4'b0011, 32'hBEEF_BEEF));
        vt.push_back(mkv(ADD, 0, 3'b100, 32'h3000, 1, 32'hDEAD_BEEF,
                         32'h3001, 1, 4'b1111, 32'hDEAD_BEEF));
        vt.push_back(mkv(ADD, 4'b0001, 0, 32'h4000, 5, 0, 32'h4005,
                         1, 4'b0000, 0));
        vt.push_back(mkv(ADD, 4'b1000, 0, 32'h5000, 2, 0, 32'h5002,
                         1, 4'b0000, 0));

        repeat (2) @(negedge clk);
        chk("rst_allowin", 86'(es_allowin), 86'd1);
        chk("rst_valid", 86'(es_to_ms_valid), 86'd0);
        chk("rst_bus", es_to_ms_bus, 86'd0);
        chk("rst_en", 86'(data_sram_en), 86'd0);
        chk("rst_wen", 86'(data_sram_wen), 86'd0);
        chk("rst_addr", 86'(data_sram_addr), 86'd0);
        chk("rst_wdata", 86'(data_sram_wdata), 86'd0);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            b = mkbus(vt[i].alu, vt[i].ld, vt[i].st, 2'b00, 5'(i),
                      vt[i].s1, vt[i].s2, vt[i].sd,
                      32'h1c00_0000 + 32'(i * 4));
            eb = {11'b0, vt[i].ld, |vt[i].ld, ~|vt[i].st, 5'(i),
                  vt[i].res, 32'h1c00_0000 + 32'(i * 4)};
            send(b);
            chk($sformatf("v%0d_valid", i), 86'(es_to_ms_valid), 86'd1);
            chk($sformatf("v%0d_bus", i), es_to_ms_bus, eb);
            chk($sformatf("v%0d_en", i), 86'(data_sram_en),
                86'(vt[i].en));
            chk($sformatf("v%0d_wen", i), 86'(data_sram_wen),
                86'(vt[i].wen));
            if (vt[i].en)
                chk($sformatf("v%0d_addr", i), 86'(data_sram_addr),
                    86'({vt[i].res[31:2], 2'b00}));
            if (vt[i].st != 3'b000)
                chk($sformatf("v%0d_wdata", i), 86'(data_sram_wdata),
                    86'(vt[i].wdata));
            @(negedge clk);
            chk($sformatf("v%0d_once", i), 86'(data_sram_en), 86'd0);
            chk($sformatf("v%0d_drain", i), 86'(es_to_ms_valid), 86'd0);
        end

        ms_allowin = 1'b0;
        send(mkbus(ADD, 4'b0100, 0, 0, 5'd9, 32'h2000, 2, 0,
                   32'h1c00_0200));
        for (int k = 0; k < 3; k++) begin
            chk("lh_stall_en", 86'(data_sram_en), 86'd0);
            chk("lh_stall_valid", 86'(es_to_ms_valid), 86'd1);
            chk("lh_stall_allowin", 86'(es_allowin), 86'd0);
            if (k < 2) @(negedge clk);
        end
        ms_allowin = 1'b1;
        #1;
        chk("lh_rel_en", 86'(data_sram_en), 86'd1);
        chk("lh_rel_wen", 86'(data_sram_wen), 86'd0);
        chk("lh_rel_addr", 86'(data_sram_addr), 86'h2000);
        chk("lh_rel_ext", 86'(es_to_ms_bus[74:71]), 86'b0100);
        chk("lh_rel_res", 86'(es_to_ms_bus[63:32]), 86'h2002);
        @(negedge clk);
        chk("lh_once", 86'(data_sram_en), 86'd0);

`ifdef EXE_DIV_EN
        run_div("div_neg", 2'b01, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        run_div("divu_z", 2'b10, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_div("div_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000);
        run_div("div_z_neg", 2'b01, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_div("div_7_m2", 2'b01, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_div("divu_big", 2'b10, 32'hFFFF_FFF0, 32'h10, 32'h0FFF_FFFF);

        send(mkbus(0, 0, 0, 2'b10, 5'd4, 32'd100, 32'd9, 0, 32'h40));
        wait_valid(c);
        chk("b2b_lat1", 86'(c), 86'd33);
        chk("b2b_res1", 86'(es_to_ms_bus[63:32]), 86'd11);
        chk("b2b_allowin", 86'(es_allowin), 86'd1);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mkbus(0, 0, 0, 2'b01, 5'd5, 32'hFFFF_FFEC,
                               32'd5, 0, 32'h44);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        chk("b2b_idle", 86'(es_to_ms_valid), 86'd0);
        wait_valid(c);
        chk("b2b_lat2", 86'(c), 86'd33);
        chk("b2b_res2", 86'(es_to_ms_bus[63:32]), 86'hFFFF_FFFC);
        chk("b2b_pc2", 86'(es_to_ms_bus[31:0]), 86'h44);
        ms_allowin = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_valid", 86'(es_to_ms_valid), 86'd1);
        chk("hold_res", 86'(es_to_ms_bus[63:32]), 86'hFFFF_FFFC);
        chk("hold_en", 86'(data_sram_en), 86'd0);
        ms_allowin = 1'b1;
        @(negedge clk);
        chk("hold_gone", 86'(es_to_ms_valid), 86'd0);

        send(mkbus(0, 0, 0, 2'b01, 5'd6, 32'd50, 32'd3, 0, 32'h48));
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstdiv_valid", 86'(es_to_ms_valid), 86'd0);
        chk("rstdiv_allowin", 86'(es_allowin), 86'd1);
        chk("rstdiv_bus", es_to_ms_bus, 86'd0);
        run_div("after_rst", 2'b01, 32'd50, 32'd3, 32'd16);
`else
        send(mkbus(ADD, 0, 0, 2'b01, 5'd7, 32'd3, 32'd4, 0, 32'h80));
        chk("nodiv_valid", 86'(es_to_ms_valid), 86'd1);
        chk("nodiv_res", 86'(es_to_ms_bus[63:32]), 86'd7);
        @(negedge clk);
        send(mkbus(SUB, 0, 0, 2'b10, 5'd8, 32'd9, 32'd4, 0, 32'h84));
        chk("nodivu_valid", 86'(es_to_ms_valid), 86'd1);
        chk("nodivu_res", 86'(es_to_ms_bus[63:32]), 86'd5);
        ms_allowin = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ms_allowin = 1'b1;
        chk("rsthold_valid", 86'(es_to_ms_valid), 86'd0);
        chk("rsthold_allowin", 86'(es_allowin), 86'd1);
        chk("rsthold_bus", es_to_ms_bus, 86'd0);
        wait_valid(c);
        chk("rsthold_quiet", 86'(c), 86'd100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
